// File: rtl/gemm_operand_loader_if.sv
// Serial operand stream between the upstream producer and gemm_operand_loader.
// The master drives words; the slave (loader) returns in_ready.
interface gemm_operand_loader_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;

  modport master (output in_valid, in_data, in_last, input in_ready);
  modport slave  (input in_valid, in_data, in_last, output in_ready);
endinterface

// File: rtl/gemm_operand_loader.sv
// Packs an 8-word stream into the 2x2 GEMM core's A/B operands, pulses issue,
// and mirrors the core's fixed latency to flag when its result is valid.
module gemm_operand_loader #(
  parameter int DATA_WIDTH   = 32,
  parameter int CORE_LATENCY = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  gemm_operand_loader_if.slave    s_if,
  output logic [4*DATA_WIDTH-1:0] A,
  output logic [4*DATA_WIDTH-1:0] B,
  output logic                    issue,
  output logic                    res_valid,
  output logic                    inflight,
  output logic                    err_len
);

  typedef enum logic [0:0] {ST_COLLECT = 1'b0, ST_DRAIN = 1'b1} state_t;

  state_t                  state_r, state_next_s;
  logic [2:0]              idx_r, idx_next_s;
  logic                    ready_r;
  logic                    issue_r, issue_next_s;
  logic                    err_r, err_next_s;
  logic [CORE_LATENCY-1:0] lat_r, lat_next_s;
  logic                    inflight_r, inflight_next_s;
  logic                    hs_s, capture_s, load_s;
  logic [DATA_WIDTH-1:0]   coll_r [0:6];
  logic [4*DATA_WIDTH-1:0] a_r, b_r;

  assign hs_s        = s_if.in_valid & ready_r;
  assign s_if.in_ready = ready_r;
  assign A           = a_r;
  assign B           = b_r;
  assign issue       = issue_r;
  assign res_valid   = lat_r[CORE_LATENCY-1];
  assign inflight    = inflight_r;
  assign err_len     = err_r;

  // Next-state logic: packet framing, error detection and latency tracking
  always_comb begin
    state_next_s    = state_r;
    idx_next_s      = idx_r;
    issue_next_s    = 1'b0;
    err_next_s      = err_r;
    capture_s       = 1'b0;
    load_s          = 1'b0;
    case (state_r)
      ST_COLLECT: begin
        if (hs_s) begin
          if (s_if.in_last) begin
            idx_next_s = 3'd0;
            if (idx_r == 3'd7) begin
              load_s       = 1'b1;
              issue_next_s = 1'b1;
            end else begin
              err_next_s = 1'b1;
            end
          end else if (idx_r == 3'd7) begin
            err_next_s   = 1'b1;
            idx_next_s   = 3'd0;
            state_next_s = ST_DRAIN;
          end else begin
            capture_s  = 1'b1;
            idx_next_s = idx_r + 3'd1;
          end
        end else begin
          idx_next_s = idx_r;
        end
      end
      ST_DRAIN: begin
        if (hs_s && s_if.in_last) begin
          state_next_s = ST_COLLECT;
          idx_next_s   = 3'd0;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      default: begin
        state_next_s = ST_COLLECT;
        idx_next_s   = 3'd0;
      end
    endcase
    // Inflight is precomputed so it can be a register like every other output
    lat_next_s      = {lat_r[CORE_LATENCY-2:0], issue_r};
    inflight_next_s = issue_next_s | (|lat_next_s);
  end

  // Control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_COLLECT;
      idx_r      <= 3'd0;
      ready_r    <= 1'b0;
      issue_r    <= 1'b0;
      err_r      <= 1'b0;
      lat_r      <= {CORE_LATENCY{1'b0}};
      inflight_r <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      idx_r      <= idx_next_s;
      ready_r    <= 1'b1;
      issue_r    <= issue_next_s;
      err_r      <= err_next_s;
      lat_r      <= lat_next_s;
      inflight_r <= inflight_next_s;
    end
  end

  // Collect buffer and output operands; the 8th word bypasses the buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 7; i++) begin
        coll_r[i] <= {DATA_WIDTH{1'b0}};
      end
      a_r <= {(4*DATA_WIDTH){1'b0}};
      b_r <= {(4*DATA_WIDTH){1'b0}};
    end else begin
      if (capture_s) begin
        coll_r[idx_r] <= s_if.in_data;
      end
      if (load_s) begin
        a_r <= {coll_r[3], coll_r[2], coll_r[1], coll_r[0]};
        b_r <= {s_if.in_data, coll_r[6], coll_r[5], coll_r[4]};
      end
    end
  end

endmodule

// File: tb/tb_gemm_operand_loader.sv
// Directed self-checking bench for gemm_operand_loader: framing, gaps,
// back-to-back packets, length errors and reset behaviour.
module tb_gemm_operand_loader;

  logic         clk;
  logic         rst_n;
  logic [127:0] a_s, b_s;
  logic         issue_s, res_valid_s, inflight_s, err_len_s;
  int           checks;
  int           errors;
  int           issue_cnt;
  int           res_cnt;

  gemm_operand_loader_if #(.DATA_WIDTH(32)) bus ();

  gemm_operand_loader #(.DATA_WIDTH(32), .CORE_LATENCY(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_if      (bus),
    .A         (a_s),
    .B         (b_s),
    .issue     (issue_s),
    .res_valid (res_valid_s),
    .inflight  (inflight_s),
    .err_len   (err_len_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (issue_s === 1'b1) issue_cnt++;
    if (res_valid_s === 1'b1) res_cnt++;
  end

  function automatic logic [127:0] pack4(input logic [31:0] base);
    return {base + 32'd3, base + 32'd2, base + 32'd1, base};
  endfunction

  // Reference 2x2 product with the same element packing as the operands
  function automatic logic [127:0] core_mul(input logic [127:0] a, input logic [127:0] b);
    logic [127:0] r;
    logic [31:0]  acc;
    r = 128'd0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        acc = a[32*(2*i) +: 32] * b[32*j +: 32] + a[32*(2*i+1) +: 32] * b[32*(2+j) +: 32];
        r[32*(2*i+j) +: 32] = acc;
      end
    end
    return r;
  endfunction

  task automatic tick(input logic v, input logic [31:0] d, input logic l);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_last  = l;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 32'd0, 1'b0);
  endtask

  task automatic send_packet(input logic [31:0] base);
    for (int i = 0; i < 8; i++) tick(1'b1, base + i, (i == 7));
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", bus.in_ready); end
    checks++; if (a_s !== 128'd0 || b_s !== 128'd0) begin errors++; $display("FAIL reset_ab got %h %h exp 0", a_s, b_s); end
    checks++; if ({issue_s, res_valid_s, inflight_s, err_len_s} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", {issue_s, res_valid_s, inflight_s, err_len_s}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b exp 1", bus.in_ready); end
  endtask

  task automatic test_single();
    int cnt;
    logic [127:0] prod;
    send_packet(32'd1);
    checks++; if (issue_s !== 1'b1) begin errors++; $display("FAIL single_issue got %b exp 1", issue_s); end
    checks++; if (a_s !== 128'h00000004_00000003_00000002_00000001) begin errors++; $display("FAIL single_a got %h", a_s); end
    checks++; if (b_s !== 128'h00000008_00000007_00000006_00000005) begin errors++; $display("FAIL single_b got %h", b_s); end
    cnt = (inflight_s === 1'b1) ? 1 : 0;
    for (int i = 1; i <= 6; i++) begin
      idle(1);
      if (inflight_s === 1'b1) cnt++;
      checks++; if (res_valid_s !== (i == 6)) begin errors++; $display("FAIL single_res_valid cyc %0d got %b exp %b", i, res_valid_s, (i == 6)); end
      if (i == 6) begin
        prod = core_mul(a_s, b_s);
        checks++; if (prod !== 128'h00000032_0000002B_00000016_00000013) begin errors++; $display("FAIL single_out got %h", prod); end
      end
    end
    idle(1);
    checks++; if (inflight_s !== 1'b0 || res_valid_s !== 1'b0) begin errors++; $display("FAIL single_tail got %b%b exp 00", inflight_s, res_valid_s); end
    checks++; if (cnt !== 7) begin errors++; $display("FAIL single_inflight_len got %0d exp 7", cnt); end
    idle(2);
  endtask

  task automatic test_back_to_back();
    int ic, rc;
    ic = issue_cnt;
    rc = res_cnt;
    for (int i = 0; i < 16; i++) begin
      tick(1'b1, (i < 8) ? 32'h10 + i : 32'h20 + i - 8, (i == 7 || i == 15));
      if (i == 7) begin
        checks++; if (issue_s !== 1'b1) begin errors++; $display("FAIL b2b_issue1 got %b exp 1", issue_s); end
      end
      if (i >= 7 && i <= 14) begin
        checks++; if (a_s !== pack4(32'h10) || b_s !== pack4(32'h14)) begin errors++; $display("FAIL b2b_hold1 word %0d got %h %h", i, a_s, b_s); end
      end
      if (i == 13) begin
        checks++; if (res_valid_s !== 1'b1) begin errors++; $display("FAIL b2b_res1 got %b exp 1", res_valid_s); end
      end
    end
    bus.in_valid = 1'b0;
    checks++; if (issue_s !== 1'b1) begin errors++; $display("FAIL b2b_issue2 got %b exp 1", issue_s); end
    checks++; if (a_s !== pack4(32'h20) || b_s !== pack4(32'h24)) begin errors++; $display("FAIL b2b_ab2 got %h %h", a_s, b_s); end
    idle(6);
    checks++; if (res_valid_s !== 1'b1) begin errors++; $display("FAIL b2b_res2 got %b exp 1", res_valid_s); end
    idle(1);
    checks++; if (issue_cnt - ic !== 2 || res_cnt - rc !== 2) begin errors++; $display("FAIL b2b_counts got %0d %0d exp 2 2", issue_cnt - ic, res_cnt - rc); end
    idle(2);
  endtask

  task automatic test_gaps();
    tick(1'b1, 32'd1, 1'b0);
    tick(1'b1, 32'd2, 1'b0);
    idle(3);
    for (int i = 3; i <= 6; i++) tick(1'b1, i, 1'b0);
    idle(1);
    tick(1'b1, 32'd7, 1'b0);
    checks++; if (a_s !== pack4(32'h20)) begin errors++; $display("FAIL gaps_hold got %h", a_s); end
    tick(1'b1, 32'd8, 1'b1);
    bus.in_valid = 1'b0;
    checks++; if (issue_s !== 1'b1) begin errors++; $display("FAIL gaps_issue got %b exp 1", issue_s); end
    checks++; if (a_s !== 128'h00000004_00000003_00000002_00000001 || b_s !== 128'h00000008_00000007_00000006_00000005) begin errors++; $display("FAIL gaps_ab got %h %h", a_s, b_s); end
    idle(1);
    checks++; if (issue_s !== 1'b0) begin errors++; $display("FAIL gaps_pulse got %b exp 0", issue_s); end
    idle(8);
  endtask

  task automatic test_err_short();
    int ic;
    ic = issue_cnt;
    checks++; if (err_len_s !== 1'b0) begin errors++; $display("FAIL short_err_pre got %b exp 0", err_len_s); end
    tick(1'b1, 32'hA0, 1'b0);
    tick(1'b1, 32'hA1, 1'b0);
    tick(1'b1, 32'hA2, 1'b1);
    idle(1);
    checks++; if (err_len_s !== 1'b1) begin errors++; $display("FAIL short_err got %b exp 1", err_len_s); end
    idle(2);
    checks++; if (issue_cnt !== ic) begin errors++; $display("FAIL short_no_issue got %0d exp %0d", issue_cnt, ic); end
    send_packet(32'h30);
    checks++; if (issue_s !== 1'b1 || a_s !== pack4(32'h30) || b_s !== pack4(32'h34)) begin errors++; $display("FAIL short_next got %b %h %h", issue_s, a_s, b_s); end
    idle(8);
  endtask

  task automatic test_err_long();
    int ic;
    ic = issue_cnt;
    for (int i = 0; i < 8; i++) tick(1'b1, 32'h90 + i, 1'b0);
    tick(1'b1, 32'h98, 1'b0);
    tick(1'b1, 32'h99, 1'b1);
    idle(2);
    checks++; if (issue_cnt !== ic) begin errors++; $display("FAIL long_no_issue got %0d exp %0d", issue_cnt, ic); end
    checks++; if (err_len_s !== 1'b1) begin errors++; $display("FAIL long_err got %b exp 1", err_len_s); end
    checks++; if (a_s !== pack4(32'h30) || b_s !== pack4(32'h34)) begin errors++; $display("FAIL long_hold got %h %h", a_s, b_s); end
    send_packet(32'h40);
    checks++; if (issue_s !== 1'b1 || a_s !== pack4(32'h40) || b_s !== pack4(32'h44)) begin errors++; $display("FAIL long_next got %b %h %h", issue_s, a_s, b_s); end
    idle(8);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) tick(1'b1, 32'h50 + i, 1'b0);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b0 || a_s !== 128'd0 || b_s !== 128'd0) begin errors++; $display("FAIL rmid_zero got %b %h %h", bus.in_ready, a_s, b_s); end
    checks++; if ({issue_s, res_valid_s, inflight_s, err_len_s} !== 4'b0000) begin errors++; $display("FAIL rmid_flags got %b exp 0000", {issue_s, res_valid_s, inflight_s, err_len_s}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b exp 1", bus.in_ready); end
    send_packet(32'h60);
    checks++; if (issue_s !== 1'b1 || a_s !== pack4(32'h60) || b_s !== pack4(32'h64)) begin errors++; $display("FAIL rmid_next got %b %h %h", issue_s, a_s, b_s); end
    idle(8);
  endtask

  task automatic test_reset_inflight();
    int rc;
    send_packet(32'h70);
    checks++; if (issue_s !== 1'b1) begin errors++; $display("FAIL rinf_issue got %b exp 1", issue_s); end
    idle(3);
    rc = res_cnt;
    rst_n = 1'b0;
    #1;
    checks++; if ({issue_s, res_valid_s, inflight_s} !== 3'b000 || a_s !== 128'd0) begin errors++; $display("FAIL rinf_zero got %b %h", {issue_s, res_valid_s, inflight_s}, a_s); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(8);
    checks++; if (res_cnt !== rc) begin errors++; $display("FAIL rinf_cancel got %0d exp %0d", res_cnt, rc); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rinf_ready got %b exp 1", bus.in_ready); end
    send_packet(32'h80);
    checks++; if (issue_s !== 1'b1 || a_s !== pack4(32'h80) || b_s !== pack4(32'h84)) begin errors++; $display("FAIL rinf_next got %b %h %h", issue_s, a_s, b_s); end
    idle(6);
    checks++; if (res_valid_s !== 1'b1) begin errors++; $display("FAIL rinf_res got %b exp 1", res_valid_s); end
    idle(2);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    issue_cnt    = 0;
    res_cnt      = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 32'd0;
    bus.in_last  = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_gaps();
    test_err_short();
    test_err_long();
    test_reset_mid();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
